// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO feeding one router output port; tracks the bytes left in the current packet.
// Optional status ports (occupancy, almost_full) are built when PFIFO_STATUS_EN is defined.
module router_pkt_fifo #(
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 16,
  parameter  int AF_MARGIN = 2,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] dout,
  output logic              pkt_busy,
  output logic              ovf,
`ifdef PFIFO_STATUS_EN
  output logic [ADDR_W:0]   occupancy,
  output logic              almost_full,
`endif
  output logic              udf
);

  localparam int PR_W = DATA_W - 1;

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || AF_MARGIN >= DEPTH) begin : g_bad_params
    $error("router_pkt_fifo: DEPTH must be a power of 2 >= 4 and AF_MARGIN < DEPTH");
  end

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [PR_W-1:0]   pkt_rem_q, pkt_rem_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_fire, rd_fire;
  logic [DATA_W:0]   rd_entry;

  assign full     = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_fire  = wr_en && !full;
  assign rd_fire  = rd_en && !empty;
  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pkt_rem_d = pkt_rem_q;
    dout_d    = dout_q;
    ovf_d     = ovf_q | (wr_en && full);
    udf_d     = udf_q | (rd_en && empty);
    if (soft_rst) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      pkt_rem_d = '0;
      dout_d    = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        dout_d   = rd_entry[DATA_W-1:0];
        // Header reload covers the payload plus the trailing parity byte.
        if (rd_entry[DATA_W])
          pkt_rem_d = PR_W'(rd_entry[DATA_W-1:2]) + PR_W'(1);
        else if (pkt_rem_q != '0)
          pkt_rem_d = pkt_rem_q - PR_W'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_rem_q <= '0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_rem_q <= pkt_rem_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage is deliberately left out of reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (!soft_rst && wr_fire) mem_q[wr_ptr_q] <= {lfd_state, din};
  end

  assign dout     = dout_q;
  assign pkt_busy = (pkt_rem_q != '0);
  assign ovf      = ovf_q;
  assign udf      = udf_q;

`ifdef PFIFO_STATUS_EN
  assign occupancy   = count_q;
  assign almost_full = (count_q >= (ADDR_W+1)'(DEPTH - AF_MARGIN));
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed self-checking bench for router_pkt_fifo (DATA_W=8, DEPTH=16).
module tb_router_pkt_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] din = '0;
  logic       full, empty, pkt_busy, ovf, udf;
  logic [7:0] dout;
`ifdef PFIFO_STATUS_EN
  logic [4:0] occupancy;
  logic       almost_full;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .AF_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .wr_en(wr_en), .rd_en(rd_en),
    .lfd_state(lfd_state), .din(din), .full(full), .empty(empty), .dout(dout),
    .pkt_busy(pkt_busy), .ovf(ovf),
`ifdef PFIFO_STATUS_EN
    .occupancy(occupancy), .almost_full(almost_full),
`endif
    .udf(udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    wr_en = 1'b1; din = d; lfd_state = lfd;
    tick();
    wr_en = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic rdwr(input logic [7:0] d);
    rd_en = 1'b1; wr_en = 1'b1; din = d;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    // Power-on reset
    repeat (2) tick();
    chk("por_empty", empty, 1);
    chk("por_full", full, 0);
    chk("por_dout", dout, 8'h00);
    rst = 1'b1;
    tick();

    // Fill / overflow / drain
    for (int i = 0; i < 16; i++) begin
      wr(8'(i), 1'b0);
      if (i == 14) chk("fill15_full", full, 0);
    end
    chk("fill16_full", full, 1);
    chk("fill16_empty", empty, 0);
    chk("fill16_ovf", ovf, 0);
    wr(8'hAA, 1'b0);
    chk("ovf_set", ovf, 1);
    chk("ovf_count", dut.count_q, 16);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk($sformatf("drain_%0d", i), dout, 8'(i));
    end
    chk("drain_empty", empty, 1);

    // Packet tracking: header 0x14 -> length 5 -> pkt_rem 6
    wr(8'h14, 1'b1);
    for (int i = 0; i < 6; i++) wr(8'h30 + 8'(i), 1'b0);
    rd();
    chk("hdr_dout", dout, 8'h14);
    chk("hdr_pkt_rem", dut.pkt_rem_q, 6);
    chk("hdr_busy", pkt_busy, 1);
    for (int i = 0; i < 6; i++) begin
      rd();
      chk($sformatf("pay_dout_%0d", i), dout, 8'h30 + 8'(i));
      chk($sformatf("pay_busy_%0d", i), pkt_busy, (i < 5) ? 1 : 0);
    end

    // Simultaneous read/write at count 8
    for (int i = 0; i < 8; i++) wr(8'h40 + 8'(i), 1'b0);
    rdwr(8'h50);
    chk("rw8_dout", dout, 8'h40);
    chk("rw8_count", dut.count_q, 8);
    for (int i = 1; i < 8; i++) rd();
    chk("rw8_tail", dout, 8'h47);
    rd();
    chk("rw8_new", dout, 8'h50);
    chk("rw8_empty", empty, 1);

    // Simultaneous read/write at full
    for (int i = 0; i < 16; i++) wr(8'h60 + 8'(i), 1'b0);
    rdwr(8'h99);
    chk("rwf_dout", dout, 8'h60);
    chk("rwf_full", full, 0);
    chk("rwf_count", dut.count_q, 15);
    for (int i = 1; i < 16; i++) rd();
    chk("rwf_last", dout, 8'h6F);
    chk("rwf_empty", empty, 1);

    // Simultaneous read/write at empty: write only, dout held, udf raised
    rdwr(8'h77);
    chk("rwe_count", dut.count_q, 1);
    chk("rwe_dout", dout, 8'h6F);
    chk("rwe_udf", udf, 1);
    rd();
    chk("rwe_read", dout, 8'h77);

    // Async reset mid-stream at count 5 with a packet in flight
    wr(8'h14, 1'b1);
    for (int i = 0; i < 5; i++) wr(8'h20 + 8'(i), 1'b0);
    rd();
    chk("pre_rst_busy", pkt_busy, 1);
    chk("pre_rst_count", dut.count_q, 5);
    rst = 1'b0;
    #2;
    chk("rst_dout", dout, 8'h00);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", pkt_busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    tick();
    rst = 1'b1;
    tick();

    // Wrap-around
    for (int i = 0; i < 10; i++) wr(8'h80 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) rd();
    chk("wrap_pre", dout, 8'h89);
    for (int i = 0; i < 10; i++) wr(8'hC0 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      rd();
      chk($sformatf("wrap_%0d", i), dout, 8'hC0 + 8'(i));
    end

    // Underflow
    rd();
    chk("udf_set", udf, 1);
    chk("udf_dout", dout, 8'hC9);
    chk("udf_empty", empty, 1);

    // Soft reset beats a same-cycle write
    for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i), 1'b0);
    soft_rst = 1'b1; wr_en = 1'b1; din = 8'hEE;
    tick();
    soft_rst = 1'b0; wr_en = 1'b0;
    chk("srst_empty", empty, 1);
    chk("srst_udf", udf, 0);
    chk("srst_dout", dout, 8'h00);
    wr(8'hF1, 1'b0);
    chk("srst_count", dut.count_q, 1);
    rd();
    chk("srst_first", dout, 8'hF1);
    chk("srst_drained", empty, 1);

`ifdef PFIFO_STATUS_EN
    for (int i = 0; i < 13; i++) wr(8'(i), 1'b0);
    chk("af13", almost_full, 0);
    chk("occ13", occupancy, 13);
    wr(8'h0D, 1'b0);
    chk("af14", almost_full, 1);
    chk("occ14", occupancy, 14);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
